// File: rtl/img_frame_sram_if.sv
// Bundle of the core pixel ports and the host load/dump streams for one
// frame-buffer plane. The core/host side uses master, the buffer uses slave.
interface img_frame_sram_if #(
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8
);
  localparam int XAW = $clog2(X_MAX) + 1;
  localparam int YAW = $clog2(Y_MAX) + 1;
  localparam int XCW = $clog2(X_MAX);
  localparam int YCW = $clog2(Y_MAX);

  logic [XAW-1:0]         x_addr_rd;
  logic [YAW-1:0]         y_addr_rd;
  logic                   ren;
  logic [PIXEL_DEPTH-1:0] rdat;
  logic [XAW-1:0]         x_addr_wr;
  logic [YAW-1:0]         y_addr_wr;
  logic                   wen;
  logic [PIXEL_DEPTH-1:0] wdat;
  logic [XCW-1:0]         max_x;
  logic [YCW-1:0]         max_y;
  logic                   load_start;
  logic                   load_valid;
  logic [PIXEL_DEPTH-1:0] load_data;
  logic                   load_ready;
  logic                   dump_start;
  logic                   dump_valid;
  logic [PIXEL_DEPTH-1:0] dump_data;
  logic                   dump_ready;
  logic                   dump_last;
  logic                   busy;
  logic                   done;
  logic                   oob_err;

  modport master (
    output x_addr_rd, y_addr_rd, ren, x_addr_wr, y_addr_wr, wen, wdat,
           max_x, max_y, load_start, load_valid, load_data, dump_start, dump_ready,
    input  rdat, load_ready, dump_valid, dump_data, dump_last, busy, done, oob_err
  );

  modport slave (
    input  x_addr_rd, y_addr_rd, ren, x_addr_wr, y_addr_wr, wen, wdat,
           max_x, max_y, load_start, load_valid, load_data, dump_start, dump_ready,
    output rdat, load_ready, dump_valid, dump_data, dump_last, busy, done, oob_err
  );
endinterface

// File: rtl/img_frame_sram.sv
// Behavioural frame buffer: core read/write ports with one-cycle read latency,
// plus a host raster load stream and a raster dump stream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for load_start / dump_start (load wins a tie)
// S_LOAD     | accepting one host pixel per cycle at the raster position
// S_DUMP_RD  | fetching the pixel at the raster position
// S_DUMP_OUT | presenting the fetched pixel until the host accepts it
module img_frame_sram #(
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8
) (
  input logic             clk,
  input logic             n_rst,
  img_frame_sram_if.slave bus_if
);
  localparam int XAW   = $clog2(X_MAX) + 1;
  localparam int YAW   = $clog2(Y_MAX) + 1;
  localparam int XCW   = $clog2(X_MAX);
  localparam int YCW   = $clog2(Y_MAX);
  localparam int DEPTH = X_MAX * Y_MAX;
  localparam int IW    = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_DUMP_RD  = 2'd2;
  localparam logic [1:0] S_DUMP_OUT = 2'd3;

  localparam logic [XCW-1:0] X_LAST = XCW'(X_MAX - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(Y_MAX - 1);

  logic [PIXEL_DEPTH-1:0] mem [DEPTH];

  logic [1:0]             state_q, state_d;
  logic [XCW-1:0]         x_q, x_d, max_x_q, max_x_d;
  logic [YCW-1:0]         y_q, y_d, max_y_q, max_y_d;
  logic                   done_q, done_d;
  logic [PIXEL_DEPTH-1:0] rdat_q, dump_data_q;
  logic                   oob_err_q;

  logic [IW-1:0]          rd_idx, wr_idx, rast_idx;
  logic                   rd_oob, wr_oob;
  logic                   last_pix, load_we, core_we;
  logic [XCW-1:0]         x_nxt;
  logic [YCW-1:0]         y_nxt;

  function automatic logic [IW-1:0] lin(input logic [IW-1:0] x, input logic [IW-1:0] y);
    return y * IW'(X_MAX) + x;
  endfunction

  assign rd_oob   = (bus_if.x_addr_rd >= XAW'(X_MAX)) || (bus_if.y_addr_rd >= YAW'(Y_MAX));
  assign wr_oob   = (bus_if.x_addr_wr >= XAW'(X_MAX)) || (bus_if.y_addr_wr >= YAW'(Y_MAX));
  assign rd_idx   = lin(IW'(bus_if.x_addr_rd), IW'(bus_if.y_addr_rd));
  assign wr_idx   = lin(IW'(bus_if.x_addr_wr), IW'(bus_if.y_addr_wr));
  assign rast_idx = lin(IW'(x_q), IW'(y_q));

  assign last_pix = (x_q == max_x_q) && (y_q == max_y_q);
  assign x_nxt    = (x_q == max_x_q) ? '0 : x_q + 1'b1;
  assign y_nxt    = (x_q == max_x_q) ? y_q + 1'b1 : y_q;

  // A reset edge aborts a load, so the beat on that edge is not stored.
  assign load_we  = n_rst && (state_q == S_LOAD) && bus_if.load_valid;
  // The host load owns the word when both ports target the same address.
  assign core_we  = bus_if.wen && !wr_oob && !(load_we && (wr_idx == rast_idx));

  // Next-state logic for the raster sequencer.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus_if.load_start || bus_if.dump_start) begin
          state_d = bus_if.load_start ? S_LOAD : S_DUMP_RD;
          max_x_d = (bus_if.max_x > X_LAST) ? X_LAST : bus_if.max_x;
          max_y_d = (bus_if.max_y > Y_LAST) ? Y_LAST : bus_if.max_y;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_LOAD: begin
        if (bus_if.load_valid) begin
          if (last_pix) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            x_d = x_nxt;
            y_d = y_nxt;
          end
        end
      end
      S_DUMP_RD: state_d = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (bus_if.dump_ready) begin
          if (last_pix) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            x_d     = x_nxt;
            y_d     = y_nxt;
            state_d = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      done_q  <= done_d;
    end
  end

  // Storage writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (core_we) mem[wr_idx] <= bus_if.wdat;
    if (load_we) mem[rast_idx] <= bus_if.load_data;
  end

  // Core read port and out-of-range flag; reads see the pre-write word.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rdat_q    <= '0;
      oob_err_q <= 1'b0;
    end else begin
      if (bus_if.ren) rdat_q <= rd_oob ? '0 : mem[rd_idx];
      oob_err_q <= (bus_if.ren && rd_oob) || (bus_if.wen && wr_oob);
    end
  end

  // Dump fetch; the value is held while the host stalls in DUMP_OUT.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dump_data_q <= '0;
    end else if (state_q == S_DUMP_RD) begin
      dump_data_q <= mem[rast_idx];
    end
  end

  assign bus_if.rdat       = rdat_q;
  assign bus_if.oob_err    = oob_err_q;
  assign bus_if.load_ready = (state_q == S_LOAD);
  assign bus_if.dump_valid = (state_q == S_DUMP_OUT);
  assign bus_if.dump_data  = dump_data_q;
  assign bus_if.dump_last  = (state_q == S_DUMP_OUT) && last_pix;
  assign bus_if.busy       = (state_q != S_IDLE);
  assign bus_if.done       = done_q;
endmodule

// File: tb/tb_img_frame_sram.sv
// Directed bench for img_frame_sram: load, core reads, dump with stalls,
// read-first collision, out-of-range accesses, start priority, reset abort.
module tb_img_frame_sram;
  localparam int X_MAX = 400;
  localparam int Y_MAX = 400;
  localparam int PD    = 8;

  logic clk = 1'b0;
  logic n_rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  img_frame_sram_if #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .PIXEL_DEPTH(PD)) bus_if ();

  img_frame_sram #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .PIXEL_DEPTH(PD)) u_dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .bus_if (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_read(input int x, input int y);
    bus_if.ren       = 1'b1;
    bus_if.x_addr_rd = 10'(x);
    bus_if.y_addr_rd = 10'(y);
    tick();
    bus_if.ren = 1'b0;
  endtask

  initial begin
    int k, cyc;
    logic [7:0] exp_px;

    n_rst             = 1'b0;
    bus_if.x_addr_rd  = '0;
    bus_if.y_addr_rd  = '0;
    bus_if.ren        = 1'b0;
    bus_if.x_addr_wr  = '0;
    bus_if.y_addr_wr  = '0;
    bus_if.wen        = 1'b0;
    bus_if.wdat       = '0;
    bus_if.max_x      = 9'd3;
    bus_if.max_y      = 9'd2;
    bus_if.load_start = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = '0;
    bus_if.dump_start = 1'b0;
    bus_if.dump_ready = 1'b0;
    tick();
    tick();

    chk("rst_rdat", bus_if.rdat, 0);
    chk("rst_load_ready", bus_if.load_ready, 0);
    chk("rst_dump_valid", bus_if.dump_valid, 0);
    chk("rst_dump_data", bus_if.dump_data, 0);
    chk("rst_dump_last", bus_if.dump_last, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_oob", bus_if.oob_err, 0);
    n_rst = 1'b1;
    tick();

    // Both starts together: load must win.
    bus_if.load_start = 1'b1;
    bus_if.dump_start = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    bus_if.dump_start = 1'b0;
    chk("prio_load_ready", bus_if.load_ready, 1);
    chk("prio_busy", bus_if.busy, 1);

    // 4x3 raster load, pixel = 16*y+x, with a stray dump_start mid-load.
    for (int i = 0; i < 12; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 8'(16 * (i / 4) + (i % 4));
      bus_if.dump_start = (i == 5);
      tick();
      if (i < 11) begin
        chk("load_no_done", bus_if.done, 0);
        chk("load_ready_held", bus_if.load_ready, 1);
        chk("load_no_dump", bus_if.dump_valid, 0);
      end
    end
    bus_if.load_valid = 1'b0;
    bus_if.dump_start = 1'b0;
    chk("load_done", bus_if.done, 1);
    chk("load_busy_fall", bus_if.busy, 0);
    tick();
    chk("load_done_pulse", bus_if.done, 0);
    chk("load_idle_no_dump", bus_if.busy, 0);

    core_read(2, 1);
    chk("rd_2_1", bus_if.rdat, 8'h12);
    core_read(3, 2);
    chk("rd_3_2", bus_if.rdat, 8'h23);
    bus_if.x_addr_rd = '0;
    bus_if.y_addr_rd = '0;
    tick();
    chk("rd_hold", bus_if.rdat, 8'h23);

    // Dump with dump_ready low for two cycles, high for two.
    bus_if.dump_start = 1'b1;
    tick();
    bus_if.dump_start = 1'b0;
    chk("dump_first_gap", bus_if.dump_valid, 0);
    chk("dump_busy", bus_if.busy, 1);
    tick();
    chk("dump_first_valid", bus_if.dump_valid, 1);
    k   = 0;
    cyc = 0;
    while (k < 12 && cyc < 200) begin
      if (bus_if.dump_valid) begin
        exp_px = 8'(16 * (k / 4) + (k % 4));
        chk("dump_data", bus_if.dump_data, exp_px);
        chk("dump_last", bus_if.dump_last, (k == 11) ? 1 : 0);
      end else begin
        chk("dump_last_idle", bus_if.dump_last, 0);
      end
      bus_if.dump_ready = ((cyc >> 1) & 1) != 0;
      if (bus_if.dump_valid && bus_if.dump_ready) k++;
      tick();
      cyc++;
    end
    bus_if.dump_ready = 1'b0;
    chk("dump_count", k, 12);
    chk("dump_done", bus_if.done, 1);
    chk("dump_busy_fall", bus_if.busy, 0);
    tick();
    chk("dump_done_pulse", bus_if.done, 0);

    // Same-address read and write: read-first.
    bus_if.ren       = 1'b1;
    bus_if.x_addr_rd = 10'd1;
    bus_if.y_addr_rd = 10'd1;
    bus_if.wen       = 1'b1;
    bus_if.x_addr_wr = 10'd1;
    bus_if.y_addr_wr = 10'd1;
    bus_if.wdat      = 8'hAA;
    tick();
    bus_if.wen = 1'b0;
    chk("raw_old", bus_if.rdat, 8'h11);
    tick();
    bus_if.ren = 1'b0;
    chk("raw_new", bus_if.rdat, 8'hAA);
    chk("raw_no_oob", bus_if.oob_err, 0);

    // Out-of-range read and write.
    bus_if.ren       = 1'b1;
    bus_if.x_addr_rd = 10'd400;
    bus_if.y_addr_rd = 10'd0;
    bus_if.wen       = 1'b1;
    bus_if.x_addr_wr = 10'd0;
    bus_if.y_addr_wr = 10'd400;
    bus_if.wdat      = 8'h55;
    tick();
    bus_if.ren = 1'b0;
    bus_if.wen = 1'b0;
    chk("oob_rdat", bus_if.rdat, 0);
    chk("oob_err", bus_if.oob_err, 1);
    tick();
    chk("oob_pulse", bus_if.oob_err, 0);
    bus_if.wen       = 1'b1;
    bus_if.x_addr_wr = 10'd401;
    bus_if.y_addr_wr = 10'd0;
    tick();
    bus_if.wen = 1'b0;
    chk("oob_wr_only", bus_if.oob_err, 1);
    core_read(0, 0);
    chk("oob_mem_0_0", bus_if.rdat, 8'h00);
    core_read(1, 0);
    chk("oob_mem_1_0", bus_if.rdat, 8'h01);

    // Reset after 5 load beats aborts without done.
    bus_if.load_start = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 8'(8'h80 + i);
      tick();
    end
    bus_if.load_valid = 1'b0;
    n_rst = 1'b0;
    tick();
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_done", bus_if.done, 0);
    chk("abort_ready", bus_if.load_ready, 0);
    n_rst = 1'b1;
    tick();
    chk("abort_no_late_done", bus_if.done, 0);
    core_read(0, 1);
    chk("abort_kept_0_1", bus_if.rdat, 8'h84);
    core_read(1, 1);
    chk("abort_kept_1_1", bus_if.rdat, 8'hAA);

    // Fresh load restarts at (0,0).
    bus_if.load_start = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 8'(8'hC0 + i);
      tick();
    end
    bus_if.load_valid = 1'b0;
    chk("reload_done", bus_if.done, 1);
    core_read(0, 0);
    chk("reload_0_0", bus_if.rdat, 8'hC0);
    core_read(3, 2);
    chk("reload_3_2", bus_if.rdat, 8'hCB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
